// File: rtl/ramb4_s8_fifo_ctrl.sv
// ramb4_s8_fifo_ctrl
// Single-clock FIFO controller for a 512x8 dual-port block RAM.
// Port A of the RAM is the write port and port B is the read port.
// This block owns the pointers, the occupancy count and the flags.
// It presents a push/pop interface to the surrounding logic.
//
// Optional feature macro: RAMB4_FIFO_ERR_EN
//   When defined, this block adds the sticky o_overflow and o_underflow outputs.
//
// Ports:
//   i_clk        single clock (also clocks both RAM ports)
//   i_rst        synchronous active-high reset
//   i_wr_en      push request            i_wr_data  push data
//   i_rd_en      pop request             o_rd_data  pop data (from i_dob)
//   o_full       count == 2^ADDR_W       o_empty    count == 0
//   o_rd_valid   o_rd_data holds a popped word
//   o_count      current occupancy (ADDR_W+1 bits)
//   o_addra/o_dia/o_ena/o_wea   RAM port A (write)
//   o_addrb/o_enb/o_web         RAM port B (read), o_web tied low
//   o_rsta/o_rstb               RAM output resets, tied low
//   i_dob        RAM port B read data
//   o_overflow/o_underflow      sticky error flags (only with RAMB4_FIFO_ERR_EN)
module ramb4_s8_fifo_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_full,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic [ADDR_W-1:0] o_addra,
  output logic [DATA_W-1:0] o_dia,
  output logic              o_ena,
  output logic              o_wea,
  output logic [ADDR_W-1:0] o_addrb,
  output logic              o_enb,
  output logic              o_web,
  output logic              o_rsta,
  output logic              o_rstb,
`ifdef RAMB4_FIFO_ERR_EN
  output logic              o_overflow,
  output logic              o_underflow,
`endif
  input  logic [DATA_W-1:0] i_dob
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_rd_valid;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [ADDR_W:0]   w_count_nxt;

  // Acceptance uses only the registered flags. Reset masks both RAM enables.
  // With registered flags the read and write addresses never collide:
  // equal pointers mean empty (pop blocked) or full (push blocked).
  assign w_push_ok = i_wr_en & ~r_full  & ~i_rst;
  assign w_pop_ok  = i_rd_en & ~r_empty & ~i_rst;

  assign o_addra    = r_wr_ptr;
  assign o_dia      = i_wr_data;
  assign o_ena      = w_push_ok;
  assign o_wea      = w_push_ok;
  assign o_addrb    = r_rd_ptr;
  assign o_enb      = w_pop_ok;
  assign o_web      = 1'b0;
  assign o_rsta     = 1'b0;
  assign o_rstb     = 1'b0;
  assign o_rd_data  = i_dob;
  assign o_rd_valid = r_rd_valid;
  assign o_count    = r_count;
  assign o_full     = r_full;
  assign o_empty    = r_empty;

  // Next occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + {{ADDR_W{1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{ADDR_W{1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, count, flags and the read-valid strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= {ADDR_W{1'b0}};
      r_rd_ptr   <= {ADDR_W{1'b0}};
      r_count    <= {(ADDR_W+1){1'b0}};
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == DEPTH);
      r_empty    <= (w_count_nxt == {(ADDR_W+1){1'b0}});
      r_rd_valid <= w_pop_ok;
    end
  end

`ifdef RAMB4_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

  // Sticky error flags: set on a request against a blocking flag, clear only on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow  | (i_wr_en & r_full);
      r_underflow <= r_underflow | (i_rd_en & r_empty);
    end
  end
`endif

endmodule
